// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcode constants and datapath mux-select / ALU-class encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// Immediate-format select, derived from the opcode alone so it is valid in
// every state (including while the instruction is still being fetched).
module instr_decoder
  import riscv_mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  // opcode -> immediate format; unknown opcodes fall back to I-type
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE: ImmSrc = IMM_S;
      OP_BEQ:   ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM.
//
//   state    | meaning
//   FETCH    | read instruction, PC <= PC+4 when memory is ready
//   DECODE   | compute branch/jump target into ALUOut, dispatch on opcode
//   MEMADR   | rs1 + imm address for load/store
//   MEMREAD  | load access, wait for mem_ready
//   MEMWB    | write load data to rd, retire
//   MEMWRITE | store access, MemWrite held until mem_ready, then retire
//   EXECR    | register-register ALU op
//   EXECI    | register-immediate ALU op
//   ALUWB    | write ALUOut to rd, retire
//   BEQ      | compare rs1/rs2, take branch on Zero, retire
//   JAL      | PC <= target, ALUOut <= PC+4 for link
//
// All 1-bit strobes are gated by rst_n so they drop the moment reset
// asserts, independent of the clock.
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t state, state_next;
  logic   pc_update, branch;
  logic   mem_write_c, ir_write_c, reg_write_c, illegal_c, done_c;

  instr_decoder u_instr_decoder (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  // state register, asynchronously forced to FETCH by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // next-state and per-state output decode
  always_comb begin
    state_next  = state;
    pc_update   = 1'b0;
    branch      = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    done_c      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_update  = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BEQ:            state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default: begin
            illegal_c  = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_RDATA;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          done_c     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNC;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        branch     = 1'b1;
        done_c     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // strobes forced low for as long as reset is held
  always_comb begin
    PCWrite    = rst_n & (pc_update | (branch & Zero));
    IRWrite    = rst_n & ir_write_c;
    MemWrite   = rst_n & mem_write_c;
    RegWrite   = rst_n & reg_write_c;
    illegal_op = rst_n & illegal_c;
    instr_done = rst_n & done_c;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each cycle the expected
// output vector for the state the instruction should be in is pushed to a
// scoreboard queue, then popped and compared against the DUT at the
// falling edge.
module tb_multicycle_controller;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL
  } tst_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal_op, instr_done;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .illegal_op (illegal_op),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op, instr_done};
  endfunction

  // expected outputs for a given state, written out from the control table
  function automatic logic [16:0] expv(tst_t s, logic [6:0] o, logic z, logic mr);
    logic pcw, adr, mw, irw, rw, ill, dn;
    logic [1:0] rs, a, b, alu, imm;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; dn = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 2'b00;
    case (o)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (s)
      T_FETCH:    begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      T_DECODE:   begin
        a = 2'b01; b = 2'b01;
        ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                          7'b0010011, 7'b1100011, 7'b1101111});
      end
      T_MEMADR:   begin a = 2'b10; b = 2'b01; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; dn = mr; end
      T_EXECR:    begin a = 2'b10; alu = 2'b10; end
      T_EXECI:    begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      T_ALUWB:    begin rw = 1; dn = 1; end
      T_BEQ:      begin a = 2'b10; alu = 2'b01; pcw = z; dn = 1; end
      T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      default:    ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill, dn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive, push expectation, sample at negedge, advance
  task automatic step(input tst_t s, input logic mr);
    mem_ready = mr;
    exp_q.push_back(expv(s, op, Zero, mr));
    @(negedge clk);
    chk($sformatf("%s_op%b_mr%0d", s.name(), op, mr), {15'd0, obs()}, {15'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic run_tied(input logic [6:0] o, input logic z, input tst_t s1,
                          input tst_t s2, input tst_t s3, input int n);
    op = o; Zero = z;
    step(T_FETCH, 1);
    step(T_DECODE, 1);
    if (n > 2) step(s1, 1);
    if (n > 3) step(s2, 1);
    if (n > 4) step(s3, 1);
  endtask

  initial begin
    rst_n = 0; op = 7'b0110011; Zero = 0; mem_ready = 1;
    #3;
    chk("rst_strobes", {26'd0, PCWrite, IRWrite, MemWrite, RegWrite, illegal_op, instr_done}, 32'd0);
    chk("rst_outputs", {15'd0, obs()}, {15'd0, expv(T_FETCH, op, 0, 0)});
    mem_ready = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // tied-high cycle counts and per-state outputs
    run_tied(7'b0000011, 0, T_MEMADR, T_MEMREAD, T_MEMWB, 5);
    run_tied(7'b0100011, 0, T_MEMADR, T_MEMWRITE, T_FETCH, 4);
    run_tied(7'b0110011, 0, T_EXECR, T_ALUWB, T_FETCH, 4);
    run_tied(7'b0010011, 1, T_EXECI, T_ALUWB, T_FETCH, 4);
    run_tied(7'b1100011, 1, T_BEQ, T_FETCH, T_FETCH, 3);
    run_tied(7'b1100011, 0, T_BEQ, T_FETCH, T_FETCH, 3);
    run_tied(7'b1101111, 0, T_JAL, T_ALUWB, T_FETCH, 4);
    run_tied(7'b1111111, 0, T_FETCH, T_FETCH, T_FETCH, 2);
    run_tied(7'b0000000, 1, T_FETCH, T_FETCH, T_FETCH, 2);

    // fetch stall, then mem_ready toggling in non-memory states
    op = 7'b0010011; Zero = 0;
    for (int i = 0; i < 3; i++) step(T_FETCH, 0);
    step(T_FETCH, 1);
    step(T_DECODE, 0);
    step(T_EXECI, 0);
    step(T_ALUWB, 1);

    // load with MEMREAD stall
    op = 7'b0000011;
    step(T_FETCH, 1); step(T_DECODE, 1); step(T_MEMADR, 0);
    step(T_MEMREAD, 0); step(T_MEMREAD, 0); step(T_MEMREAD, 1); step(T_MEMWB, 0);

    // store with MEMWRITE stall, completes normally
    op = 7'b0100011;
    step(T_FETCH, 1); step(T_DECODE, 1); step(T_MEMADR, 1);
    step(T_MEMWRITE, 0); step(T_MEMWRITE, 0); step(T_MEMWRITE, 1);

    // store aborted by reset mid-MEMWRITE
    step(T_FETCH, 1); step(T_DECODE, 1); step(T_MEMADR, 0);
    mem_ready = 0;
    #1;
    chk("abort_mw_before", {31'd0, MemWrite}, 32'd1);
    rst_n = 0; mem_ready = 1;
    #1;
    chk("abort_mw_async", {31'd0, MemWrite}, 32'd0);
    chk("abort_strobes", {26'd0, PCWrite, IRWrite, MemWrite, RegWrite, illegal_op, instr_done}, 32'd0);
    #1;
    rst_n = 1; op = 7'b0110011;
    step(T_FETCH, 1); step(T_DECODE, 1); step(T_EXECR, 1); step(T_ALUWB, 1);
    step(T_FETCH, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
